// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    localparam int REG_AW_DEF = 5;

    // Encoding loaded into IF/ID or ID/EX by a flush: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating event counter for stall statistics.
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencing (load-use, branch flush, mul/div, memory wait).
// Optional stall counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int MD_MAX_CYC = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_MemRead,
    input  logic              ex_BrTaken,
    input  logic              ex_md_req,
    input  logic              md_done,
    input  logic              im_ready,
    input  logic              dm_ready,
    output logic              pc_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              md_start,
    output logic              md_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int WD_W = $clog2(MD_MAX_CYC);

    hz_state_e       state, state_nx;
    logic [WD_W-1:0] wd, wd_nx;
    logic            md_done_q, md_done_q_nx, md_err_nx;
    logic            mem_ok, load_use, done, wd_exp;

    assign mem_ok   = im_ready & dm_ready;
    assign load_use = ex_MemRead && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    assign done     = md_done | md_done_q;
    assign wd_exp   = wd == WD_W'(MD_MAX_CYC - 1);

    always_comb begin
        pc_en        = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        md_start     = 1'b0;
        state_nx     = state;
        wd_nx        = wd;
        md_done_q_nx = md_done_q;
        md_err_nx    = md_err;
        if (!mem_ok) begin
            pc_en    = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            if (state == RUN)
                state_nx = MEM_WAIT;
            if (state == MD_BUSY && md_done)
                md_done_q_nx = 1'b1;
        end else if (state == MD_BUSY) begin
            pc_en    = 1'b0;
            idex_en  = 1'b0;
            exmem_en = done | wd_exp;
            if (done || wd_exp) begin
                state_nx     = RUN;
                md_done_q_nx = 1'b0;
                md_err_nx    = md_err | (wd_exp & ~done);
            end else
                wd_nx = wd + 1'b1;
        end else begin
            // MEM_WAIT releasing behaves exactly like a RUN cycle
            state_nx = RUN;
            if (ex_md_req) begin
                md_start = 1'b1;
                pc_en    = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                state_nx = MD_BUSY;
                wd_nx    = '0;
            end else if (ex_BrTaken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wd        <= '0;
            md_done_q <= 1'b0;
            md_err    <= 1'b0;
        end else begin
            state     <= state_nx;
            wd        <= wd_nx;
            md_done_q <= md_done_q_nx;
            md_err    <= md_err_nx;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(.W(CNT_W)) u_perf (
        .clk (clk),
        .rst (rst),
        .inc (~pc_en),
        .cnt (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_MemRead, ex_BrTaken, ex_md_req, md_done, im_ready, dm_ready;
    logic        pc_en, idex_en, exmem_en, ifid_flush, idex_flush, md_start, md_err;
    logic [31:0] stall_cnt;
    logic [5:0]  outs, e;
    int          n_cmp = 0, n_err = 0, stall_exp = 0;

    assign outs = {pc_en, idex_en, exmem_en, ifid_flush, idex_flush, md_start};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_rd      (ex_rd),
        .ex_MemRead (ex_MemRead),
        .ex_BrTaken (ex_BrTaken),
        .ex_md_req  (ex_md_req),
        .md_done    (md_done),
        .im_ready   (im_ready),
        .dm_ready   (dm_ready),
        .pc_en      (pc_en),
        .idex_en    (idex_en),
        .exmem_en   (exmem_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .md_start   (md_start),
        .md_err     (md_err),
        .stall_cnt  (stall_cnt)
    );

    task automatic set_in(input logic [4:0] rs1, rs2, rd,
                          input logic mr, br, mdr, mdd, imr, dmr);
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_MemRead = mr; ex_BrTaken = br; ex_md_req = mdr; md_done = mdd;
        im_ready = imr; dm_ready = dmr;
    endtask

    task automatic drive(input logic [4:0] rs1, rs2, rd,
                         input logic mr, br, mdr, mdd, imr, dmr);
        @(negedge clk);
        set_in(rs1, rs2, rd, mr, br, mdr, mdd, imr, dmr);
        #2;
    endtask

    task automatic test_reset;
        set_in(5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 1, 1);
        #2;
        e = 6'b111000;
        if (outs !== e) begin n_err++; $display("FAIL reset_outs got %b want %b", outs, e); end
        n_cmp++;
        if (md_err !== 1'b0) begin n_err++; $display("FAIL reset_md_err got %b want 0", md_err); end
        n_cmp++;
        if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use;
        drive(5'd3, 5'd5, 5'd5, 1, 0, 0, 0, 1, 1);
        e = 6'b011010;
        if (outs !== e) begin n_err++; $display("FAIL ld_use_rs2 got %b want %b", outs, e); end
        n_cmp++; stall_exp += !e[5];
        drive(5'd3, 5'd5, 5'd0, 0, 0, 0, 0, 1, 1);
        e = 6'b111000;
        if (outs !== e) begin n_err++; $display("FAIL ld_use_after got %b want %b", outs, e); end
        n_cmp++; stall_exp += !e[5];
        drive(5'd7, 5'd2, 5'd7, 1, 0, 0, 0, 1, 1);
        e = 6'b011010;
        if (outs !== e) begin n_err++; $display("FAIL ld_use_rs1 got %b want %b", outs, e); end
        n_cmp++; stall_exp += !e[5];
        drive(5'd7, 5'd2, 5'd9, 1, 0, 0, 0, 1, 1);
        e = 6'b111000;
        if (outs !== e) begin n_err++; $display("FAIL ld_no_match got %b want %b", outs, e); end
        n_cmp++; stall_exp += !e[5];
    endtask

    task automatic test_x0;
        drive(5'd0, 5'd4, 5'd0, 1, 0, 0, 0, 1, 1);
        e = 6'b111000;
        if (outs !== e) begin n_err++; $display("FAIL ld_x0 got %b want %b", outs, e); end
        n_cmp++; stall_exp += !e[5];
    endtask

    task automatic test_branch;
        drive(5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 1, 1);
        e = 6'b111110;
        if (outs !== e) begin n_err++; $display("FAIL br_over_lu got %b want %b", outs, e); end
        n_cmp++; stall_exp += !e[5];
    endtask

    task automatic test_muldiv;
        for (int c = 0; c <= 6; c++) begin
            drive(5'd1, 5'd2, 5'd3, 0, 0, c < 6, c == 5, 1, 1);
            e = (c == 0) ? 6'b000001 : (c < 5) ? 6'b000000 : (c == 5) ? 6'b001000 : 6'b111000;
            if (outs !== e) begin n_err++; $display("FAIL md_c%0d got %b want %b", c, outs, e); end
            n_cmp++; stall_exp += !e[5];
        end
    endtask

    task automatic test_md_latch;
        for (int c = 0; c <= 3; c++) begin
            drive(5'd1, 5'd2, 5'd3, 0, 0, c == 0, c == 1, 1, c != 1);
            e = (c == 0) ? 6'b000001 : (c == 1) ? 6'b000000 : (c == 2) ? 6'b001000 : 6'b111000;
            if (outs !== e) begin n_err++; $display("FAIL md_latch_c%0d got %b want %b", c, outs, e); end
            n_cmp++; stall_exp += !e[5];
        end
    endtask

    task automatic test_mem_wait;
        for (int c = 0; c <= 4; c++) begin
            drive(5'd1, 5'd2, 5'd3, 0, c < 4, 0, 0, 1, c >= 3);
            e = (c < 3) ? 6'b000000 : (c == 3) ? 6'b111110 : 6'b111000;
            if (outs !== e) begin n_err++; $display("FAIL memw_c%0d got %b want %b", c, outs, e); end
            n_cmp++; stall_exp += !e[5];
        end
    endtask

    task automatic test_watchdog;
        for (int c = 0; c <= 66; c++) begin
            drive(5'd1, 5'd2, 5'd3, 0, 0, c == 0, 0, 1, 1);
            e = (c == 0) ? 6'b000001 : (c < 64) ? 6'b000000 : (c == 64) ? 6'b001000 : 6'b111000;
            if (outs !== e) begin n_err++; $display("FAIL wd_c%0d got %b want %b", c, outs, e); end
            n_cmp++; stall_exp += !e[5];
            if (c == 64 || c >= 65) begin
                if (md_err !== (c >= 65)) begin
                    n_err++; $display("FAIL wd_err_c%0d got %b want %b", c, md_err, c >= 65);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 1, 1);
        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1, 0);
        e = 6'b000000;
        if (outs !== e) begin n_err++; $display("FAIL rm_pre got %b want %b", outs, e); end
        n_cmp++;
        #1;
        rst = 1'b1;
        set_in(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1);
        #1;
        e = 6'b111000;
        if (outs !== e) begin n_err++; $display("FAIL rm_outs got %b want %b", outs, e); end
        n_cmp++;
        if (md_err !== 1'b0) begin n_err++; $display("FAIL rm_md_err got %b want 0", md_err); end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
        stall_exp = 0;
        for (int c = 0; c <= 3; c++) begin
            drive(5'd1, 5'd2, 5'd3, 0, 0, c == 0, c == 2, 1, 1);
            e = (c == 0) ? 6'b000001 : (c == 1) ? 6'b000000 : (c == 2) ? 6'b001000 : 6'b111000;
            if (outs !== e) begin n_err++; $display("FAIL rm_c%0d got %b want %b", c, outs, e); end
            n_cmp++; stall_exp += !e[5];
        end
    endtask

    task automatic test_stall_cnt;
        int want;
`ifdef HAZARD_PERF_CNT_EN
        want = stall_exp;
`else
        want = 0;
`endif
        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1);
        if (stall_cnt !== 32'(want)) begin
            n_err++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, want);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_x0;
        test_branch;
        test_muldiv;
        test_md_latch;
        test_mem_wait;
        test_watchdog;
        test_reset_mid;
        test_stall_cnt;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
